fa_response_checker: RTL and testbench
======================================

FA_RESPONSE_CHECKER -- requirements
Module: fa_response_checker

Interface
REQ-001 The module SHALL have parameter SIG_SEED, default 8'hFF, the MISR seed loaded on reset and on run start.
REQ-002 The module SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 The module SHALL have port start  input  1  begin a check run (8 vectors).
REQ-005 The module SHALL have port in_valid  input  1  the a/b/cin/s/cout inputs hold one applied vector and its response this cycle.
REQ-006 The module SHALL have ports a, b, cin  input  1 each  stimulus applied to the full adder under test.
REQ-007 The module SHALL have ports s, cout  input  1 each  response of the full adder under test.
REQ-008 The module SHALL have port busy  output  1  run in progress.
REQ-009 The module SHALL have port done  output  1  one-cycle pulse at end of run.
REQ-010 The module SHALL have port pass  output  1  last completed run had zero errors; held until the next start.
REQ-011 The module SHALL have port err_count  output  4  errors in the current or last run, range 0..8.
REQ-012 The module SHALL have port first_err_idx  output  3  vector index of the first error; 0 if none.
REQ-013 The module SHALL have port signature  output  8  MISR signature of the responses.

Function
REQ-014 FSM states SHALL be IDLE, RUN, DONE; a start pulse in IDLE or DONE SHALL enter RUN on the next edge.
REQ-015 On entry to RUN, the module SHALL clear idx, err_count, first_err_idx and pass, and SHALL load SIG_SEED into the MISR.
REQ-016 In RUN, each in_valid cycle SHALL be one accepted sample, and idx (3-bit, 0..7) SHALL advance by 1 per sample.
REQ-017 Expected response SHALL be s_exp = a^b^cin and cout_exp = (a&b)|(a&cin)|(b&cin).
REQ-018 A sample SHALL count as one error if s!=s_exp, cout!=cout_exp, or {a,b,cin}!=idx (out-of-order stimulus); a sample SHALL add at most 1 to err_count.
REQ-019 On the first erroneous sample of a run, first_err_idx SHALL capture idx.
REQ-020 The 8th sample (idx==7) SHALL move the FSM to DONE, and done SHALL pulse high for exactly the cycle after that sample.
REQ-021 In DONE, pass SHALL equal (err_count==0), and the results SHALL hold until the next start.
REQ-022 busy SHALL be 1 exactly while in RUN.
REQ-023 start while in RUN SHALL be ignored, and the run SHALL continue.
REQ-024 in_valid in IDLE or DONE SHALL be ignored, and no outputs SHALL change.
REQ-025 If start and in_valid are both high in IDLE or DONE, the sample SHALL be ignored, and RUN SHALL begin with idx=0.
REQ-026 Gaps of any length between in_valid cycles SHALL be allowed, with no timeout.

Reset
REQ-027 rst high SHALL immediately force IDLE and set busy=0, done=0, pass=0, err_count=0, first_err_idx=0, idx=0 and MISR=SIG_SEED, including mid-run.
REQ-028 After rst deasserts, the module SHALL stay in IDLE until a start is seen.

Configuration
REQ-029 With macro FA_CHK_MISR_EN defined, the MISR SHALL be built: on each accepted sample it SHALL shift with polynomial x^8+x^4+x^3+x^2+1, with bit0 XORed with s and bit1 XORed with cout, and signature SHALL be the MISR value.
REQ-030 With FA_CHK_MISR_EN undefined, the MISR SHALL be omitted and signature SHALL be constant 8'h00, and all other behaviour SHALL be unchanged.

Structure
REQ-031 A shared package fa_chk_pkg SHALL hold the state enum (IDLE/RUN/DONE), VEC_COUNT=8, MISR_POLY=8'h1D and the expected-response function.
REQ-032 One sub-module, fa_chk_misr (8-bit MISR with load, enable and 2-bit data inputs), SHALL be instantiated only under FA_CHK_MISR_EN.

Verification
REQ-033 Verification SHALL cover this case: start, then 8 samples with {a,b,cin}=0..7 and correct s/cout -> done one cycle after the 8th sample, pass=1, err_count=0, first_err_idx=0.
REQ-034 Verification SHALL cover this case: the same run with s inverted at vectors 3 and 5 -> err_count=2, first_err_idx=3, pass=0.
REQ-035 Verification SHALL cover this case: stimulus order 0,1,2,4,3,5,6,7 with correct responses -> err_count=2, first_err_idx=3.
REQ-036 Verification SHALL cover this case: start pulsed again at sample 4, plus in_valid pulses while in IDLE -> both ignored; done still arrives after 8 RUN samples.
REQ-037 Verification SHALL cover this case: rst asserted after sample 5, then a new full correct run -> outputs cleared asynchronously, second run pass=1.
REQ-038 Verification SHALL cover this case: with FA_CHK_MISR_EN defined, a correct run -> signature matches the bench model seeded with 8'hFF; without the macro -> signature=8'h00.

Source files
------------

// File: rtl/fa_chk_pkg.sv
// Shared types and constants for the full-adder response checker.
// Holds the run FSM states, vector count, MISR polynomial and the golden full-adder model.
package fa_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chk_state_e;

  localparam int unsigned VEC_COUNT = 8;
  localparam logic [2:0]  LAST_IDX  = 3'(VEC_COUNT - 1);
  localparam logic [7:0]  MISR_POLY = 8'h1D;  // x^8+x^4+x^3+x^2+1

  typedef struct packed {
    logic s;
    logic cout;
  } fa_resp_t;

  function automatic fa_resp_t fa_expected(input logic a, input logic b, input logic cin);
    fa_resp_t r;
    r.s    = a ^ b ^ cin;
    r.cout = (a & b) | (a & cin) | (b & cin);
    return r;
  endfunction

endpackage

// File: rtl/fa_chk_misr.sv
// 8-bit multiple-input signature register compacting {cout, s} responses.
// Left-shifting Galois form: MSB feedback folds in MISR_POLY, data enters bits [1:0].
module fa_chk_misr
  import fa_chk_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       en,
  input  logic [1:0] data,
  output logic [7:0] sig
);

  logic [7:0] misr_q, misr_d;

  always_comb begin
    misr_d = {misr_q[6:0], 1'b0} ^ (misr_q[7] ? MISR_POLY : 8'h00) ^ {6'b0, data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misr_q <= SEED;
    end else if (load) begin
      misr_q <= SEED;
    end else if (en) begin
      misr_q <= misr_d;
    end
  end

  assign sig = misr_q;

endmodule

// File: rtl/fa_response_checker.sv
// Checks an external full adder over one 8-vector run: counts errors, flags the first one.
// Define FA_CHK_MISR_EN to build the response MISR; otherwise signature reads 8'h00.
module fa_response_checker
  import fa_chk_pkg::*;
#(
  parameter logic [7:0] SIG_SEED = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic       s,
  input  logic       cout,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] first_err_idx,
  output logic [7:0] signature
);

  chk_state_e state_q;
  logic [2:0] idx_q;
  logic [3:0] err_count_q, err_count_d;
  logic [2:0] first_err_idx_q;
  logic       busy_q, done_q, pass_q;
  logic       start_acc, sample_acc, sample_err;
  fa_resp_t   resp_exp;

  always_comb begin
    // NOTE: every signal written here is assigned on every path, so no latch is inferred.
    resp_exp    = fa_expected(a, b, cin);
    start_acc   = start && (state_q != RUN);
    sample_acc  = in_valid && (state_q == RUN);
    // Out-of-order stimulus counts as an error even when the response itself is right.
    sample_err  = (s != resp_exp.s) || (cout != resp_exp.cout) || ({a, b, cin} != idx_q);
    err_count_d = err_count_q + {3'b000, sample_err};
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      idx_q           <= 3'd0;
      err_count_q     <= 4'd0;
      first_err_idx_q <= 3'd0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (start_acc) begin
            state_q         <= RUN;
            idx_q           <= 3'd0;
            err_count_q     <= 4'd0;
            first_err_idx_q <= 3'd0;
            pass_q          <= 1'b0;
            busy_q          <= 1'b1;
          end
        end
        RUN: begin
          if (sample_acc) begin
            idx_q       <= idx_q + 3'd1;
            err_count_q <= err_count_d;
            if (sample_err && (err_count_q == 4'd0)) begin
              first_err_idx_q <= idx_q;
            end
            if (idx_q == LAST_IDX) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_count_d == 4'd0);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_count_q;
  assign first_err_idx = first_err_idx_q;

`ifdef FA_CHK_MISR_EN
  fa_chk_misr #(.SEED(SIG_SEED)) u_misr (
    .clk  (clk),
    .rst  (rst),
    .load (start_acc),
    .en   (sample_acc),
    .data ({cout, s}),
    .sig  (signature)
  );
`else
  // Seed stays referenced so both builds expose an identical, warning-free interface.
  assign signature = SIG_SEED & 8'h00;
`endif

endmodule

// File: tb/tb_fa_response_checker.sv
// Directed bench for fa_response_checker: table of full runs plus hand-written corner sequences.
// Signature expectations follow FA_CHK_MISR_EN the same way the design build does.
`timescale 1ns/1ps
module tb_fa_response_checker;

  localparam logic [7:0] SEED = 8'hFF;

  logic       clk = 1'b0;
  logic       rst, start, in_valid, a, b, cin, s, cout;
  logic       busy, done, pass;
  logic [3:0] err_count;
  logic [2:0] first_err_idx;
  logic [7:0] signature;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] misr_m;

  typedef struct packed {
    logic [7:0][2:0] order;
    logic [7:0]      s_flip;
    logic [7:0]      c_flip;
    logic [3:0]      exp_err;
    logic [2:0]      exp_first;
    logic            exp_pass;
  } run_t;

  run_t runs[6];

  always #5 clk = ~clk;

  fa_response_checker #(.SIG_SEED(SEED)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .in_valid      (in_valid),
    .a             (a),
    .b             (b),
    .cin           (cin),
    .s             (s),
    .cout          (cout),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_count     (err_count),
    .first_err_idx (first_err_idx),
    .signature     (signature)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] misr_step(input logic [7:0] m, input logic sv, input logic cv);
    logic [7:0] n;
    n = {m[6:0], 1'b0};
    if (m[7]) n = n ^ 8'h1D;
    n[0] = n[0] ^ sv;
    n[1] = n[1] ^ cv;
    return n;
  endfunction

  function automatic logic [7:0] exp_sig();
`ifdef FA_CHK_MISR_EN
    return misr_m;
`else
    return 8'h00;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One in_valid cycle; 'counted' says whether the DUT should accept it into the model.
  task automatic send(input logic [2:0] v, input logic fs, input logic fc,
                      input logic with_start, input logic counted);
    logic maj;
    maj      = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
    {a, b, cin} = v;
    s        = (v[2] ^ v[1] ^ v[0]) ^ fs;
    cout     = maj ^ fc;
    in_valid = 1'b1;
    start    = with_start;
    tick();
    if (counted) misr_m = misr_step(misr_m, s, cout);
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic start_run(input string tag);
    start = 1'b1;
    tick();
    start  = 1'b0;
    misr_m = SEED;
    check({tag, " busy after start"}, 32'(busy), 32'd1);
    check({tag, " err cleared"}, 32'(err_count), 32'd0);
    check({tag, " first cleared"}, 32'(first_err_idx), 32'd0);
    check({tag, " pass cleared"}, 32'(pass), 32'd0);
    check({tag, " sig seeded"}, 32'(signature), 32'(exp_sig()));
  endtask

  task automatic check_done(input string tag, input logic [3:0] e, input logic [2:0] f,
                            input logic p);
    check({tag, " done pulse"}, 32'(done), 32'd1);
    check({tag, " busy low"}, 32'(busy), 32'd0);
    check({tag, " err_count"}, 32'(err_count), 32'(e));
    check({tag, " first_err_idx"}, 32'(first_err_idx), 32'(f));
    check({tag, " pass"}, 32'(pass), 32'(p));
    check({tag, " signature"}, 32'(signature), 32'(exp_sig()));
    tick();
    check({tag, " done one cycle"}, 32'(done), 32'd0);
    check({tag, " err held"}, 32'(err_count), 32'(e));
    check({tag, " pass held"}, 32'(pass), 32'(p));
  endtask

  initial begin
    runs[0] = '{order: {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0},
                s_flip: 8'h00, c_flip: 8'h00, exp_err: 4'd0, exp_first: 3'd0, exp_pass: 1'b1};
    runs[1] = '{order: {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0},
                s_flip: 8'b0010_1000, c_flip: 8'h00, exp_err: 4'd2, exp_first: 3'd3, exp_pass: 1'b0};
    runs[2] = '{order: {3'd7, 3'd6, 3'd5, 3'd3, 3'd4, 3'd2, 3'd1, 3'd0},
                s_flip: 8'h00, c_flip: 8'h00, exp_err: 4'd2, exp_first: 3'd3, exp_pass: 1'b0};
    runs[3] = '{order: {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0},
                s_flip: 8'h01, c_flip: 8'h01, exp_err: 4'd1, exp_first: 3'd0, exp_pass: 1'b0};
    runs[4] = '{order: {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0},
                s_flip: 8'hFF, c_flip: 8'h00, exp_err: 4'd8, exp_first: 3'd0, exp_pass: 1'b0};
    runs[5] = '{order: {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0},
                s_flip: 8'h00, c_flip: 8'h80, exp_err: 4'd1, exp_first: 3'd7, exp_pass: 1'b0};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    a = 1'b0; b = 1'b0; cin = 1'b0; s = 1'b0; cout = 1'b0;
    misr_m = SEED;
    repeat (2) tick();
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset pass", 32'(pass), 32'd0);
    check("reset err_count", 32'(err_count), 32'd0);
    check("reset first_err_idx", 32'(first_err_idx), 32'd0);
    check("reset signature", 32'(signature), 32'(exp_sig()));
    rst = 1'b0;
    repeat (3) tick();
    check("idle after reset", 32'(busy), 32'd0);

    // in_valid while IDLE must change nothing.
    send(3'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    send(3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    check("idle in_valid err", 32'(err_count), 32'd0);
    check("idle in_valid busy", 32'(busy), 32'd0);
    check("idle in_valid sig", 32'(signature), 32'(exp_sig()));

    for (int r = 0; r < 6; r++) begin
      string tag;
      tag = $sformatf("run%0d", r);
      start_run(tag);
      for (int i = 0; i < 8; i++) begin
        if (i == 7) check({tag, " no early done"}, 32'(done), 32'd0);
        send(runs[r].order[i], runs[r].s_flip[i], runs[r].c_flip[i], 1'b0, 1'b1);
        if (i != 7) repeat (i % 3) tick();
      end
      check_done(tag, runs[r].exp_err, runs[r].exp_first, runs[r].exp_pass);
    end

    // in_valid in DONE is ignored; start during RUN is ignored.
    send(3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("done in_valid err", 32'(err_count), 32'd1);
    check("done in_valid first", 32'(first_err_idx), 32'd7);
    start_run("restart");
    for (int i = 0; i < 8; i++) begin
      send(3'(i), 1'b0, 1'b0, (i == 4), 1'b1);
      if (i == 4) check("start in RUN ignored busy", 32'(busy), 32'd1);
      if (i == 4) check("start in RUN keeps err", 32'(err_count), 32'd0);
    end
    check_done("restart", 4'd0, 3'd0, 1'b1);

    // start with in_valid from DONE: sample dropped, run begins at idx 0.
    send(3'd6, 1'b1, 1'b0, 1'b1, 1'b0);
    misr_m = SEED;
    check("start+valid busy", 32'(busy), 32'd1);
    check("start+valid err", 32'(err_count), 32'd0);
    check("start+valid sig", 32'(signature), 32'(exp_sig()));
    for (int i = 0; i < 8; i++) send(3'(i), 1'b0, 1'b0, 1'b0, 1'b1);
    check_done("start+valid run", 4'd0, 3'd0, 1'b1);

    // Asynchronous reset mid-run clears everything before the next edge.
    start_run("rstmid");
    for (int i = 0; i < 6; i++) send(3'(i), (i == 1), 1'b0, 1'b0, 1'b1);
    check("pre-reset err", 32'(err_count), 32'd1);
    check("pre-reset first", 32'(first_err_idx), 32'd1);
    #2 rst = 1'b1;
    #1;
    misr_m = SEED;
    check("async rst busy", 32'(busy), 32'd0);
    check("async rst err", 32'(err_count), 32'd0);
    check("async rst first", 32'(first_err_idx), 32'd0);
    check("async rst done", 32'(done), 32'd0);
    check("async rst sig", 32'(signature), 32'(exp_sig()));
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("idle after mid reset", 32'(busy), 32'd0);
    start_run("post-rst");
    for (int i = 0; i < 8; i++) begin
      send(3'(i), 1'b0, 1'b0, 1'b0, 1'b1);
      repeat (2) tick();
    end
    check("post-rst done after gap", 32'(done), 32'd0);
    check("post-rst pass", 32'(pass), 32'd1);
    check("post-rst err", 32'(err_count), 32'd0);
    check("post-rst signature", 32'(signature), 32'(exp_sig()));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
